// File: rtl/player_press.sv
`timescale 1ns/1ps
// player_press: turns the two raw player keys into single-cycle press events.
//
// Each key passes through a two-flop synchronizer, an optional debounce
// filter and a two-state press detector. Only the IDLE->HELD edge counts as
// a press. The pulse outputs are registered.
//
// Optional feature: define PLAYER_PRESS_DEBOUNCE_EN to compile in the
// debounce filter. Without it the accepted level is the synchronized key, and
// DB_CYCLES is used only for its range check.
//
// Parameters:
//   DB_CYCLES  consecutive stable cycles needed to accept a level change (2..15)
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-low reset
//   keyL    raw left key, asynchronous, high = pressed
//   keyR    raw right key, asynchronous, high = pressed
//   freeze  synchronous game-over; masks L/R/tie while high
//   L       one-cycle pulse per accepted left press
//   R       one-cycle pulse per accepted right press
//   tie     one-cycle pulse when both presses are accepted on the same edge
module player_press #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic keyL,
  input  logic keyR,
  input  logic freeze,
  output logic L,
  output logic R,
  output logic tie
);

  localparam int unsigned N_CH = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } state_t;

  if (DB_CYCLES < 2 || DB_CYCLES > 15) begin : g_db_range
    $error("player_press: DB_CYCLES must be in 2..15");
  end

  // Channel 0 is the left key and channel 1 is the right key.
  logic [N_CH-1:0] w_key;
  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  logic [N_CH-1:0] w_acc;
  logic [N_CH-1:0] w_press;
  state_t          r_state [N_CH];

  assign w_key = {keyR, keyL};

  // Two-flop synchronizer for the asynchronous keys.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_key;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PLAYER_PRESS_DEBOUNCE_EN
  localparam int unsigned CNT_W = 4;

  logic [N_CH-1:0]            r_acc;
  logic [N_CH-1:0][CNT_W-1:0] r_cnt;

  // Debounce filter. The counter runs while the synchronized key disagrees
  // with the accepted level. Any agreement clears it. The level flips on the
  // edge where the counter would reach DB_CYCLES.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (r_sync2[i] == r_acc[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
          r_acc[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_acc = r_acc;
`else
  assign w_acc = r_sync2;
`endif

  // A press is an accepted high level seen while the channel is still IDLE.
  always_comb begin
    w_press = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_press[i] = (r_state[i] == S_IDLE) && w_acc[i];
    end
  end

  // Press detectors and registered outputs. The detectors keep tracking while
  // frozen, so a key held across unfreeze has already been consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        r_state[i] <= S_IDLE;
      end
      L   <= 1'b0;
      R   <= 1'b0;
      tie <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        case (r_state[i])
          S_IDLE:  if (w_acc[i])  r_state[i] <= S_HELD;
          S_HELD:  if (!w_acc[i]) r_state[i] <= S_IDLE;
          default: r_state[i] <= S_IDLE;
        endcase
      end
      L   <= w_press[0] & ~w_press[1] & ~freeze;
      R   <= w_press[1] & ~w_press[0] & ~freeze;
      tie <= w_press[0] &  w_press[1] & ~freeze;
    end
  end

endmodule

// File: tb/tb_player_press.sv
`timescale 1ns/1ps
// Bench for player_press. The reference model works on the per-edge key
// history. The accepted level flips when the synchronized key has disagreed
// with it for DB_CYCLES edges in a row, counted since the last flip. A press
// is a rise of the accepted level, seen one edge later.
module tb_player_press;

  localparam int DB   = 4;
  localparam int MAXN = 4096;
`ifdef PLAYER_PRESS_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif
  localparam int LAT = DEB ? (2 + DB) : 2;

  logic clk = 1'b0;
  logic reset, keyL, keyR, freeze;
  logic L, R, tie;

  int checks   = 0;
  int failures = 0;

  player_press #(.DB_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .keyL(keyL), .keyR(keyR), .freeze(freeze),
    .L(L), .R(R), .tie(tie)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic k_h   [2][MAXN];
  logic acc_h [2][MAXN];
  int   last_chg [2];
  int   n;

  function automatic logic s2_before(int ch, int idx);
    return (idx >= 2) ? k_h[ch][idx-2] : 1'b0;
  endfunction

  function automatic logic acc_at(int ch, int idx);
    return (idx >= 0) ? acc_h[ch][idx] : 1'b0;
  endfunction

  task automatic model_clear();
    n = 0;
    last_chg[0] = -1000;
    last_chg[1] = -1000;
  endtask

  task automatic model_edge(input logic kl, input logic kr, input logic fz,
                            output logic eL, output logic eR, output logic eT);
    logic p [2];
    logic prev;
    bit   flip;
    k_h[0][n] = kl;
    k_h[1][n] = kr;
    for (int ch = 0; ch < 2; ch++) begin
      prev = acc_at(ch, n-1);
      if (DEB) begin
        flip = (n - last_chg[ch]) >= DB;
        for (int j = 0; j < DB; j++) begin
          if ((n - j) < 0 || s2_before(ch, n - j) == prev) flip = 1'b0;
        end
        acc_h[ch][n] = flip ? ~prev : prev;
        if (flip) last_chg[ch] = n;
      end else begin
        acc_h[ch][n] = (n >= 1) ? k_h[ch][n-1] : 1'b0;
      end
      p[ch] = acc_at(ch, n-1) & ~acc_at(ch, n-2);
    end
    eL = p[0] & ~p[1] & ~fz;
    eR = p[1] & ~p[0] & ~fz;
    eT = p[0] &  p[1] & ~fz;
    if (n < MAXN - 1) n++;
  endtask

  // Drives one set of inputs, lets one rising edge go by and returns the
  // observed and modelled outputs for that edge.
  task automatic step(input logic kl, input logic kr, input logic fz,
                      output logic oL, output logic oR, output logic oT,
                      output logic eL, output logic eR, output logic eT);
    keyL = kl; keyR = kr; freeze = fz;
    @(posedge clk);
    model_edge(kl, kr, fz, eL, eR, eT);
    #1;
    oL = L; oR = R; oT = tie;
  endtask

  task automatic do_reset(input logic kl, input logic kr);
    reset = 1'b0; keyL = kl; keyR = kr; freeze = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; keyL = 1'b1; keyR = 1'b1; freeze = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (L !== 1'b0)   begin failures++; $display("FAIL reset_L got=%b want=0", L); end
    checks++; if (R !== 1'b0)   begin failures++; $display("FAIL reset_R got=%b want=0", R); end
    checks++; if (tie !== 1'b0) begin failures++; $display("FAIL reset_tie got=%b want=0", tie); end
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_single_press();
    logic oL, oR, oT, eL, eR, eT;
    int nL = 0, nRT = 0, at = -1;
    do_reset(1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 1'b0, 1'b0, oL, oR, oT, eL, eR, eT);
      checks++;
      if ({oL, oR, oT} !== {eL, eR, eT}) begin
        failures++;
        $display("FAIL single_press cyc=%0d got LRT=%b%b%b want %b%b%b", c, oL, oR, oT, eL, eR, eT);
      end
      if (oL) begin nL++; if (at < 0) at = c; end
      if (oR || oT) nRT++;
    end
    checks++; if (nL !== 1)   begin failures++; $display("FAIL single_press_count got=%0d want=1", nL); end
    checks++; if (at !== LAT) begin failures++; $display("FAIL single_press_latency got=%0d want=%0d", at, LAT); end
    checks++; if (nRT !== 0)  begin failures++; $display("FAIL single_press_other got=%0d want=0", nRT); end
  endtask

  task automatic test_bounce();
    logic oL, oR, oT, eL, eR, eT;
    int nR = 0, nLT = 0;
    do_reset(1'b0, 1'b0);
    for (int c = 0; c < 22; c++) begin
      step(1'b0, (c < 12) ? logic'(c % 2 == 0) : 1'b0, 1'b0, oL, oR, oT, eL, eR, eT);
      checks++;
      if ({oL, oR, oT} !== {eL, eR, eT}) begin
        failures++;
        $display("FAIL bounce cyc=%0d got LRT=%b%b%b want %b%b%b", c, oL, oR, oT, eL, eR, eT);
      end
      if (oR) nR++;
      if (oL || oT) nLT++;
    end
    checks++; if (nR !== (DEB ? 0 : 6)) begin failures++; $display("FAIL bounce_R_count got=%0d want=%0d", nR, DEB ? 0 : 6); end
    checks++; if (nLT !== 0) begin failures++; $display("FAIL bounce_other got=%0d want=0", nLT); end
  endtask

  task automatic test_glitch();
    logic oL, oR, oT, eL, eR, eT;
    int nR = 0;
    do_reset(1'b0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      step(1'b0, logic'(c == 0), 1'b0, oL, oR, oT, eL, eR, eT);
      checks++;
      if ({oL, oR, oT} !== {eL, eR, eT}) begin
        failures++;
        $display("FAIL glitch cyc=%0d got LRT=%b%b%b want %b%b%b", c, oL, oR, oT, eL, eR, eT);
      end
      if (oR) nR++;
    end
    checks++; if (nR !== (DEB ? 0 : 1)) begin failures++; $display("FAIL glitch_R_count got=%0d want=%0d", nR, DEB ? 0 : 1); end
  endtask

  task automatic test_tie();
    logic oL, oR, oT, eL, eR, eT;
    int nT = 0, nLR = 0, at = -1;
    do_reset(1'b0, 1'b0);
    for (int c = 0; c < LAT + 8; c++) begin
      step(1'b1, 1'b1, 1'b0, oL, oR, oT, eL, eR, eT);
      checks++;
      if ({oL, oR, oT} !== {eL, eR, eT}) begin
        failures++;
        $display("FAIL tie cyc=%0d got LRT=%b%b%b want %b%b%b", c, oL, oR, oT, eL, eR, eT);
      end
      if (oT) begin nT++; if (at < 0) at = c; end
      if (oL || oR) nLR++;
    end
    checks++; if (nT !== 1)   begin failures++; $display("FAIL tie_count got=%0d want=1", nT); end
    checks++; if (at !== LAT) begin failures++; $display("FAIL tie_latency got=%0d want=%0d", at, LAT); end
    checks++; if (nLR !== 0)  begin failures++; $display("FAIL tie_LR got=%0d want=0", nLR); end
  endtask

  task automatic test_freeze();
    logic oL, oR, oT, eL, eR, eT;
    int   len [4];
    logic klv [4];
    logic fzv [4];
    int   want [4];
    int   cnt, at;
    len  = '{LAT + 5, 10, LAT + 4, LAT + 4};
    klv  = '{1'b1, 1'b1, 1'b0, 1'b1};
    fzv  = '{1'b1, 1'b0, 1'b0, 1'b0};
    want = '{0, 0, 0, 1};
    do_reset(1'b0, 1'b0);
    for (int ph = 0; ph < 4; ph++) begin
      cnt = 0; at = -1;
      for (int c = 0; c < len[ph]; c++) begin
        step(klv[ph], 1'b0, fzv[ph], oL, oR, oT, eL, eR, eT);
        checks++;
        if ({oL, oR, oT} !== {eL, eR, eT}) begin
          failures++;
          $display("FAIL freeze ph=%0d cyc=%0d got LRT=%b%b%b want %b%b%b", ph, c, oL, oR, oT, eL, eR, eT);
        end
        if (oL) begin cnt++; if (at < 0) at = c; end
      end
      checks++;
      if (cnt !== want[ph]) begin
        failures++;
        $display("FAIL freeze_count ph=%0d got=%0d want=%0d", ph, cnt, want[ph]);
      end
    end
    checks++; if (at !== LAT) begin failures++; $display("FAIL freeze_repress_latency got=%0d want=%0d", at, LAT); end
  endtask

  task automatic test_reset_mid();
    logic oL, oR, oT, eL, eR, eT;
    int nR = 0, at = -1;
    do_reset(1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b1, 1'b0, oL, oR, oT, eL, eR, eT);
      checks++;
      if ({oL, oR, oT} !== {eL, eR, eT}) begin
        failures++;
        $display("FAIL reset_mid_pre cyc=%0d got LRT=%b%b%b want %b%b%b", c, oL, oR, oT, eL, eR, eT);
      end
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({L, R, tie} !== 3'b000) begin
        failures++;
        $display("FAIL reset_mid_hold cyc=%0d got LRT=%b%b%b want 000", c, L, R, tie);
      end
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    for (int c = 0; c < LAT + 8; c++) begin
      step(1'b0, 1'b1, 1'b0, oL, oR, oT, eL, eR, eT);
      checks++;
      if ({oL, oR, oT} !== {eL, eR, eT}) begin
        failures++;
        $display("FAIL reset_mid_post cyc=%0d got LRT=%b%b%b want %b%b%b", c, oL, oR, oT, eL, eR, eT);
      end
      if (oR) begin nR++; if (at < 0) at = c; end
    end
    checks++; if (nR !== 1)   begin failures++; $display("FAIL reset_mid_count got=%0d want=1", nR); end
    checks++; if (at !== LAT) begin failures++; $display("FAIL reset_mid_latency got=%0d want=%0d", at, LAT); end
  endtask

  task automatic test_random();
    logic oL, oR, oT, eL, eR, eT;
    logic kl, kr, fz;
    int   seg_len;
    do_reset(1'b0, 1'b0);
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 24) == 0) do_reset(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
      seg_len = $urandom_range(1, 12);
      kl = logic'($urandom_range(0, 1));
      kr = logic'($urandom_range(0, 1));
      fz = logic'($urandom_range(0, 7) == 0);
      for (int c = 0; c < seg_len; c++) begin
        step(kl, kr, fz, oL, oR, oT, eL, eR, eT);
        checks++;
        if ({oL, oR, oT} !== {eL, eR, eT}) begin
          failures++;
          $display("FAIL random seg=%0d cyc=%0d got LRT=%b%b%b want %b%b%b", s, c, oL, oR, oT, eL, eR, eT);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_glitch();
    test_tie();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
